rf_port_controller: RTL and testbench

//  Sequences the single write port of RegisterFile and protects its two read ports.
//  - Zeroes all registers after reset or on request.
//  - Arbitrates round-robin between two writeback requesters: A = ALU, B = memory/load.
//  - Keeps a pending-write scoreboard that flags read hazards.
//  - Bypasses the in-flight write onto the read data.

---
 rtl/rf_port_controller_pkg.sv | 17 +
 rtl/rf_port_controller_arbiter.sv | 39 +++
 rtl/rf_port_controller.sv | 146 ++++++++++++++
 tb/tb_rf_port_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_port_controller_pkg.sv
// Shared constants for the register-file port controller: default sizes,
// FSM state encodings and requester identifiers.
package rf_port_controller_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREG_DEF   = 32;

    // Controller FSM states
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Writeback requester identifiers (A = ALU, B = memory/load)
    localparam logic [0:0] REQ_A = 1'b0;
    localparam logic [0:0] REQ_B = 1'b1;

endpackage

// File: rtl/rf_port_controller_arbiter.sv
// Two-way round-robin arbiter for the register-file write port.
// Grants are combinational; the last winner is remembered so that when both
// requesters are valid the other one wins next.
module rf_rr_arbiter
    import rf_port_controller_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_ready,
    output logic b_ready
);

    logic [0:0] last_grant_reg;

    // Combinational grant: a lone requester wins, otherwise alternate
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (run) begin
            a_ready = a_valid && (!b_valid || (last_grant_reg == REQ_B));
            b_ready = b_valid && (!a_valid || (last_grant_reg == REQ_A));
        end
    end

    // Remember the winner of every granted cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= REQ_B;
        end else if (a_ready) begin
            last_grant_reg <= REQ_A;
        end else if (b_ready) begin
            last_grant_reg <= REQ_B;
        end
    end

endmodule

// File: rtl/rf_port_controller.sv
// Register-file write-port controller: zeroing sweep after reset or on
// request, round-robin writeback arbitration, pending-write scoreboard with
// read hazard flags, and bypass of the in-flight write onto the read data.
module rf_port_controller
    import rf_port_controller_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              init_req,
    output logic              init_busy,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] rd_a1,
    input  logic [ADDR_W-1:0] rd_a2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [ADDR_W-1:0] rf_ad,
    output logic [DATA_W-1:0] rf_di,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_do1,
    input  logic [DATA_W-1:0] rf_do2,
    output logic [DATA_W-1:0] do1,
    output logic [DATA_W-1:0] do2
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NREG - 1);

    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [NREG-1:0]   pend_reg;
    logic [NREG-1:0]   pend_next;
    logic [ADDR_W-1:0] rf_ad_reg;
    logic [DATA_W-1:0] rf_di_reg;
    logic              rf_we_reg;

    logic              run_ok;
    logic              restart;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // A restart request takes the port away in the same cycle so that no
    // accepted write is silently dropped by the sweep.
    assign restart   = (state_reg == ST_RUN) && init_req;
    assign run_ok    = (state_reg == ST_RUN) && !init_req;
    assign init_busy = (state_reg == ST_INIT);

    rf_rr_arbiter u_arb (
        .clk     (CLK),
        .rst_n   (reset),
        .run     (run_ok),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_ready (a_ready),
        .b_ready (b_ready)
    );

    assign accept   = a_ready || b_ready;
    assign win_addr = a_ready ? a_addr : b_addr;
    assign win_data = a_ready ? a_data : b_data;

    // Per-register scoreboard update: an issue beats a same-edge writeback,
    // and register 0 can never be pending.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_next[gi] = 1'b0;
            end else begin : g_reg
                assign pend_next[gi] =
                    (iss_valid && (iss_addr == ADDR_W'(gi))) ? 1'b1 :
                    (accept && (win_addr == ADDR_W'(gi)))    ? 1'b0 :
                    pend_reg[gi];
            end
        end
    endgenerate

    // FSM, sweep counter, scoreboard and registered write-port outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_INIT;
            cnt_reg   <= ADDR_ZERO;
            pend_reg  <= '0;
            rf_we_reg <= 1'b0;
            rf_ad_reg <= ADDR_ZERO;
            rf_di_reg <= '0;
        end else if (state_reg == ST_INIT) begin
            pend_reg  <= pend_next;
            rf_we_reg <= 1'b1;
            rf_ad_reg <= cnt_reg;
            rf_di_reg <= '0;
            cnt_reg   <= cnt_reg + ADDR_ONE;
            if (cnt_reg == ADDR_LAST) begin
                state_reg <= ST_RUN;
            end
        end else if (restart) begin
            pend_reg  <= '0;
            cnt_reg   <= ADDR_ZERO;
            rf_we_reg <= 1'b0;
            state_reg <= ST_INIT;
        end else begin
            pend_reg <= pend_next;
            if (accept && (win_addr != ADDR_ZERO)) begin
                rf_we_reg <= 1'b1;
                rf_ad_reg <= win_addr;
                rf_di_reg <= win_data;
            end else begin
                rf_we_reg <= 1'b0;
            end
        end
    end

    assign rf_we = rf_we_reg;
    assign rf_ad = rf_ad_reg;
    assign rf_di = rf_di_reg;

    assign hazard1 = pend_reg[rd_a1] && (rd_a1 != ADDR_ZERO);
    assign hazard2 = pend_reg[rd_a2] && (rd_a2 != ADDR_ZERO);

    // Forward the write that the RF has not stored yet
    always_comb begin
        do1 = rf_do1;
        do2 = rf_do2;
        if (rf_we_reg && (rf_ad_reg != ADDR_ZERO) && (rf_ad_reg == rd_a1)) begin
            do1 = rf_di_reg;
        end
        if (rf_we_reg && (rf_ad_reg != ADDR_ZERO) && (rf_ad_reg == rd_a2)) begin
            do2 = rf_di_reg;
        end
    end

endmodule

// File: tb/tb_rf_port_controller.sv
// Directed bench for rf_port_controller with a behavioural register file
// (async read, write on rising edge, register 0 hard zero).
module tb_rf_port_controller;

    logic        clk;
    logic        reset;
    logic        init_req;
    logic        init_busy;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  rd_a1, rd_a2;
    logic        hazard1, hazard2;
    logic [4:0]  rf_ad;
    logic [31:0] rf_di;
    logic        rf_we;
    logic [31:0] rf_do1, rf_do2;
    logic [31:0] do1, do2;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [32];

    rf_port_controller dut (
        .CLK       (clk),
        .reset     (reset),
        .init_req  (init_req),
        .init_busy (init_busy),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .rf_ad     (rf_ad),
        .rf_di     (rf_di),
        .rf_we     (rf_we),
        .rf_do1    (rf_do1),
        .rf_do2    (rf_do2),
        .do1       (do1),
        .do2       (do2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD_0000 + i;
    end
    always @(posedge clk) begin
        if (rf_we && (rf_ad != 5'd0)) mem[rf_ad] <= rf_di;
    end
    assign rf_do1 = (rd_a1 == 5'd0) ? 32'd0 : mem[rd_a1];
    assign rf_do2 = (rd_a2 == 5'd0) ? 32'd0 : mem[rd_a2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  n;
        reset = 1'b0; init_req = 1'b0;
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        iss_valid = 1'b0; iss_addr = 5'd0;
        rd_a1 = 5'd0; rd_a2 = 5'd0;

        // Reset state while held
        @(negedge clk); @(negedge clk);
        chk("rst_busy",  {31'd0, init_busy}, 32'd1);
        chk("rst_aready",{31'd0, a_ready},   32'd0);
        chk("rst_we",    {31'd0, rf_we},     32'd0);
        chk("rst_ad",    {27'd0, rf_ad},     32'd0);
        chk("rst_di",    rf_di,              32'd0);
        $display("txn reset held");

        // 1: sweep of 32 zero writes
        reset = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("sw_we",   {31'd0, rf_we},     32'd1);
            chk("sw_ad",   {27'd0, rf_ad},     k);
            chk("sw_di",   rf_di,              32'd0);
            chk("sw_busy", {31'd0, init_busy}, (k < 31) ? 32'd1 : 32'd0);
            chk("sw_ardy", {31'd0, a_ready},   32'd0);
            if (k == 30) a_valid = 1'b0;
        end
        $display("txn sweep complete");

        // 2: single A write of (5,50)
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'd50;
        #1 chk("t2_ardy", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0; rd_a1 = 5'd5;
        #1;
        chk("t2_we",  {31'd0, rf_we}, 32'd1);
        chk("t2_ad",  {27'd0, rf_ad}, 32'd5);
        chk("t2_di",  rf_di,          32'd50);
        chk("t2_byp", do1,            32'd50);
        @(negedge clk);
        chk("t2_we0", {31'd0, rf_we}, 32'd0);
        chk("t2_rf",  do1,            32'd50);
        $display("txn A write r5=50");

        // 4: hazard on r7 until B writes (7,70)
        iss_valid = 1'b1; iss_addr = 5'd7;
        @(negedge clk);
        iss_valid = 1'b0; rd_a1 = 5'd7; rd_a2 = 5'd0;
        #1;
        chk("t4_haz1", {31'd0, hazard1}, 32'd1);
        chk("t4_haz2", {31'd0, hazard2}, 32'd0);
        @(negedge clk);
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'd70;
        #1;
        chk("t4_haz1b", {31'd0, hazard1}, 32'd1);
        chk("t4_brdy",  {31'd0, b_ready}, 32'd1);
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        chk("t4_haz0",  {31'd0, hazard1}, 32'd0);
        chk("t4_old",   rf_do1,           32'd0);
        chk("t4_byp",   do1,              32'd70);
        @(negedge clk);
        chk("t4_rf",    do1,              32'd70);
        $display("txn B write r7=70 with hazard");

        // 3: both valid for 4 cycles, last grant was B -> A,B,A,B
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd30;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'd40;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_ardy", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_brdy", {31'd0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
            chk("t3_ad", {27'd0, rf_ad}, (i % 2 == 0) ? 32'd3 : 32'd4);
            chk("t3_di", rf_di,          (i % 2 == 0) ? 32'd30 : 32'd40);
            $display("txn rr grant %0d ad=%0d", i, rf_ad);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // 5: address 0 accepted but not written
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'd99;
        #1 chk("t5_ardy", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0; rd_a1 = 5'd0;
        #1;
        chk("t5_we",  {31'd0, rf_we},   32'd0);
        chk("t5_do1", do1,              32'd0);
        chk("t5_haz", {31'd0, hazard1}, 32'd0);
        $display("txn A write r0 dropped");

        // 7: same-edge issue and accept of r9 -> stays pending
        iss_valid = 1'b1; iss_addr = 5'd9;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'd90;
        #1 chk("t7_ardy", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        iss_valid = 1'b0; a_valid = 1'b0; rd_a1 = 5'd9;
        #1;
        chk("t7_haz", {31'd0, hazard1}, 32'd1);
        chk("t7_ad",  {27'd0, rf_ad},   32'd9);
        $display("txn issue+write r9 same edge");

        // init_req restart: pend cleared, sweep from 0
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        #1;
        chk("ir_busy", {31'd0, init_busy}, 32'd1);
        chk("ir_haz",  {31'd0, hazard1},   32'd0);
        chk("ir_we",   {31'd0, rf_we},     32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("ir_ad", {27'd0, rf_ad}, k);
        end
        $display("txn init_req sweep to cnt=10");

        // 6: reset mid-sweep at cnt=10, then restart from 0
        a_valid = 1'b1; a_addr = 5'd0;
        reset = 1'b0;
        #1;
        chk("t6_we",   {31'd0, rf_we},     32'd0);
        chk("t6_ad",   {27'd0, rf_ad},     32'd0);
        chk("t6_busy", {31'd0, init_busy}, 32'd1);
        chk("t6_ardy", {31'd0, a_ready},   32'd0);
        a_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_ad0", {27'd0, rf_ad}, 32'd0);
        chk("t6_we1", {31'd0, rf_we}, 32'd1);
        n = 0;
        while (init_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t6_done", {31'd0, init_busy}, 32'd0);
        @(negedge clk);
        rd_a1 = 5'd5; rd_a2 = 5'd7;
        #1;
        chk("t6_z5", do1, 32'd0);
        chk("t6_z7", do2, 32'd0);
        $display("txn reset mid-sweep and resweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
